// File: rtl/reg_alu_seq_if.sv
// Decoded-instruction channel into the sequencer.
// Valid/ready handshake; fields are sampled only in the accepting cycle.
interface reg_alu_seq_if #(
    parameter int ADSize = 5,
    parameter int DASize = 32,
    parameter int OPSize = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_type;
    logic [OPSize-1:0] in_op;
    logic [ADSize-1:0] in_rd;
    logic [ADSize-1:0] in_rs1;
    logic [ADSize-1:0] in_rs2;
    logic [DASize-1:0] in_imm;

    modport master (
        output in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_type, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready
    );
endinterface

// File: rtl/reg_alu_seq.sv
// Instruction sequencer driving register-file/ALU controls; REG_ALU_SEQ_OVF_TRAP_EN adds an overflow trap.
// Latency: LOAD retires 2 cycles after accept, ALU 4 cycles, NOP 1 cycle.
// Backpressure: in_ready only in IDLE, so one instruction is in flight at a time.
module reg_alu_seq #(
    parameter int ADSize = 5,
    parameter int DASize = 32,
    parameter int OPSize = 3
) (
    input  logic              clk,
    input  logic              rst,
    reg_alu_seq_if.slave      bus,
    output logic              Write,
    output logic              Read,
    output logic              S,
    output logic [DASize-1:0] DIN,
    output logic [ADSize-1:0] Write_ADDR,
    output logic [ADSize-1:0] Read_ADDR_1,
    output logic [ADSize-1:0] Read_ADDR_2,
    output logic [OPSize-1:0] OP,
    input  logic              Overflow,
    input  logic              ovf_clr,
    output logic              ovf_flag,
    output logic              done,
    output logic [15:0]       retired
);
    localparam logic [1:0] TYPE_NOP  = 2'b00;
    localparam logic [1:0] TYPE_LOAD = 2'b01;
    localparam logic [1:0] TYPE_ALU  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WB,
        RD,
        EX,
        ALU_WB
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t            state;
    logic              write_en;
    logic [ADSize-1:0] rd_q;
    logic              accept;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef REG_ALU_SEQ_OVF_TRAP_EN
    // Overflow arrives mid-cycle in ALU_WB, so the destination write is suppressed combinationally.
    assign Write = write_en && !((state == ALU_WB) && Overflow);
`else
    assign Write = write_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            write_en    <= 1'b0;
            Read        <= 1'b0;
            S           <= 1'b0;
            DIN         <= '0;
            Write_ADDR  <= '0;
            Read_ADDR_1 <= '0;
            Read_ADDR_2 <= '0;
            OP          <= '0;
            rd_q        <= '0;
            ovf_flag    <= 1'b0;
            done        <= 1'b0;
            retired     <= '0;
        end else begin
            done <= 1'b0;

            if ((state == ALU_WB) && Overflow) begin
                ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                ovf_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.in_type)
                            TYPE_LOAD: begin
                                write_en   <= 1'b1;
                                S          <= 1'b0;
                                DIN        <= bus.in_imm;
                                Write_ADDR <= bus.in_rd;
                                state      <= LOAD_WB;
                            end
                            TYPE_ALU: begin
                                Read        <= 1'b1;
                                Read_ADDR_1 <= bus.in_rs1;
                                Read_ADDR_2 <= bus.in_rs2;
                                OP          <= bus.in_op;
                                rd_q        <= bus.in_rd;
                                state       <= RD;
                            end
                            TYPE_NOP: begin
                                done    <= 1'b1;
                                retired <= retired + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                LOAD_WB: begin
                    write_en <= 1'b0;
                    done     <= 1'b1;
                    retired  <= retired + 16'd1;
                    state    <= IDLE;
                end
                RD: begin
                    state <= EX;
                end
                EX: begin
                    write_en   <= 1'b1;
                    S          <= 1'b1;
                    Write_ADDR <= rd_q;
                    state      <= ALU_WB;
                end
                ALU_WB: begin
                    write_en <= 1'b0;
                    S        <= 1'b0;
                    Read     <= 1'b0;
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
                    if (Overflow) begin
                        state <= TRAP;
                    end else begin
                        done    <= 1'b1;
                        retired <= retired + 16'd1;
                        state   <= IDLE;
                    end
`else
                    done    <= 1'b1;
                    retired <= retired + 16'd1;
                    state   <= IDLE;
`endif
                end
`ifdef REG_ALU_SEQ_OVF_TRAP_EN
                TRAP: begin
                    if (ovf_clr) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
